// File: rtl/sr_reg_dump_pkg.sv
// ---------------------------------------------------------------------------
// sr_reg_dump_pkg
// Shared definitions for the register-file dump port: frame constants,
// controller state encoding and the byte-select helper used to slice the
// latched register word into the outgoing byte stream.
// ---------------------------------------------------------------------------
package sr_reg_dump_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         NUM_REGS          = 32;
    localparam int         REG_ADDR_W        = 5;
    localparam int         BYTES_PER_REG     = 5;
    localparam int         FRAME_BYTES       = 1 + NUM_REGS * BYTES_PER_REG;  // 161
    localparam logic [4:0] LAST_REG          = 5'd31;
    localparam logic [2:0] LAST_BYTE_SEL     = 3'd4;
    localparam logic [3:0] STOP_BIT_IDX      = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_LATCH = 3'd3,
        ST_SEND  = 3'd4,
        ST_FIN   = 3'd5
    } dumpState_t;

    // sel 0 is the index byte, sel 1..4 walk the word MSB first.
    function automatic logic [7:0] regByte(input logic [4:0]  idx,
                                           input logic [31:0] word,
                                           input logic [2:0]  sel);
        logic [7:0] b;
        case (sel)
            3'd0:    b = {3'b000, idx};
            3'd1:    b = word[31:24];
            3'd2:    b = word[23:16];
            3'd3:    b = word[15:8];
            3'd4:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sr_reg_dump_if.sv
// ---------------------------------------------------------------------------
// sr_reg_dump_if
// Bundles the dump request/status, the register-file debug read port and
// the UART line.
//   start   : dump request (into the dump block)
//   regAddr : register-file debug read address (from the dump block)
//   regData : register-file debug read data, combinational in regAddr
//   tx      : UART serial out, idle high
//   busy    : frame in progress
//   done    : one-cycle frame-complete pulse
// master = the dump block, slave = the surrounding system.
// ---------------------------------------------------------------------------
interface sr_reg_dump_if;
    import sr_reg_dump_pkg::*;

    logic                  start;
    logic [REG_ADDR_W-1:0] regAddr;
    logic [31:0]           regData;
    logic                  tx;
    logic                  busy;
    logic                  done;

    modport master (
        input  start,
        input  regData,
        output regAddr,
        output tx,
        output busy,
        output done
    );

    modport slave (
        output start,
        output regData,
        input  regAddr,
        input  tx,
        input  busy,
        input  done
    );

endinterface

// File: rtl/sr_uart_tx.sv
// ---------------------------------------------------------------------------
// sr_uart_tx
// 8N1 UART transmitter with a valid/ready byte input.
//   clk, rst_n : clock, async active-low reset
//   data       : byte to send, taken on valid && ready
//   valid      : byte offered
//   ready      : idle, or in the last clock of the stop bit (gap-free chaining)
//   idle       : nothing shifting
//   tx         : serial out, idle high
// Each bit lasts BAUD_DIV clocks. tx is registered, so the line lags the
// internal bit state by one clock; this keeps tx glitch-free at the pad.
// ---------------------------------------------------------------------------
module sr_uart_tx
    import sr_reg_dump_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       idle,
    output logic       tx
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    logic        active;
    logic [15:0] baudCnt;
    logic [3:0]  bitIdx;
    logic [9:0]  shifter;
    logic        txReg;
    logic        bitEnd;
    logic        lastClk;

    assign bitEnd  = (baudCnt == 16'd0);
    assign lastClk = active && bitEnd && (bitIdx == STOP_BIT_IDX);
    assign ready   = !active || lastClk;
    assign idle    = !active;
    assign tx      = txReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            baudCnt <= 16'd0;
            bitIdx  <= 4'd0;
            shifter <= '1;
            txReg   <= 1'b1;
        end else begin
            txReg <= active ? shifter[0] : 1'b1;
            if (valid && ready) begin
                active  <= 1'b1;
                shifter <= {1'b1, data, 1'b0};
                bitIdx  <= 4'd0;
                baudCnt <= BAUD_LAST;
            end else if (active) begin
                if (bitEnd) begin
                    if (bitIdx == STOP_BIT_IDX) begin
                        active <= 1'b0;
                    end else begin
                        bitIdx  <= bitIdx + 4'd1;
                        shifter <= {1'b1, shifter[9:1]};
                        baudCnt <= BAUD_LAST;
                    end
                end else begin
                    baudCnt <= baudCnt - 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/sr_reg_dump.sv
// ---------------------------------------------------------------------------
// sr_reg_dump
// Walks the register-file debug read port over all 32 registers and streams
// a framed UART dump: SYNC_BYTE, then per register {index, d[31:24],
// d[23:16], d[15:8], d[7:0]}.
//   clk, rst_n : system clock (shared with the CPU), async active-low reset
//   dbg        : sr_reg_dump_if.master (start, regAddr, regData, tx, busy, done)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// SYNC  | offer SYNC_BYTE to the serializer, clear register index
// LOAD  | regAddr = r settles on the debug port
// LATCH | capture regData into the word register
// SEND  | offer index byte then the 4 word bytes; next LOAD or FIN
// FIN   | wait for the serializer to drain, pulse done
// ---------------------------------------------------------------------------
module sr_reg_dump
    import sr_reg_dump_pkg::*;
#(
    parameter int         BAUD_DIV  = 434,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    sr_reg_dump_if.master dbg
);

    dumpState_t  state, stateNext;
    logic [4:0]  regIdx;
    logic [31:0] wordReg;
    logic [2:0]  byteSel;
    logic        doneReg, doneNext;

    logic        txValid;
    logic        txReady;
    logic        txIdle;
    logic [7:0]  txData;
    logic        txFire;

    assign txFire = txValid && txReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            doneReg <= 1'b0;
        end else begin
            state   <= stateNext;
            doneReg <= doneNext;
        end
    end

    always_comb begin
        stateNext = state;
        txValid   = 1'b0;
        txData    = 8'h00;
        doneNext  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dbg.start) stateNext = ST_SYNC;
            end
            ST_SYNC: begin
                txValid = 1'b1;
                txData  = SYNC_BYTE;
                if (txReady) stateNext = ST_LOAD;
            end
            ST_LOAD: begin
                stateNext = ST_LATCH;
            end
            ST_LATCH: begin
                stateNext = ST_SEND;
            end
            ST_SEND: begin
                txValid = 1'b1;
                txData  = regByte(regIdx, wordReg, byteSel);
                if (txReady && (byteSel == LAST_BYTE_SEL)) begin
                    stateNext = (regIdx == LAST_REG) ? ST_FIN : ST_LOAD;
                end
            end
            ST_FIN: begin
                if (txIdle) begin
                    doneNext  = 1'b1;
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // Index advances together with the final byte of a register, so the new
    // address is on the port for all of LOAD and LATCH before capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regIdx  <= 5'd0;
            wordReg <= 32'd0;
            byteSel <= 3'd0;
        end else begin
            case (state)
                ST_SYNC: begin
                    regIdx  <= 5'd0;
                    byteSel <= 3'd0;
                end
                ST_LATCH: begin
                    wordReg <= dbg.regData;
                    byteSel <= 3'd0;
                end
                ST_SEND: begin
                    if (txFire) begin
                        if (byteSel == LAST_BYTE_SEL) begin
                            byteSel <= 3'd0;
                            if (regIdx != LAST_REG) regIdx <= regIdx + 5'd1;
                        end else begin
                            byteSel <= byteSel + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg.regAddr = regIdx;
    assign dbg.done    = doneReg;
    assign dbg.busy    = (state == ST_LOAD) || (state == ST_LATCH) ||
                         (state == ST_SEND) || (state == ST_FIN);

    sr_uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (txData),
        .valid (txValid),
        .ready (txReady),
        .idle  (txIdle),
        .tx    (dbg.tx)
    );

endmodule

// File: tb/tb_sr_reg_dump.sv
// ---------------------------------------------------------------------------
// tb_sr_reg_dump
// Bench for sr_reg_dump with BAUD_DIV = 4: register-file model on the debug
// port, UART decoder on tx, done-pulse recorder.
// ---------------------------------------------------------------------------
module tb_sr_reg_dump;
    import sr_reg_dump_pkg::*;

    localparam int BAUD       = 4;
    localparam int BYTE_CLKS  = 10 * BAUD;
    localparam int FRAME_CLKS = FRAME_BYTES * BYTE_CLKS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sr_reg_dump_if bus ();

    sr_reg_dump #(
        .BAUD_DIV  (BAUD),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dbg   (bus)
    );

    logic [31:0] rf    [32];
    logic [31:0] expRf [32];
    assign bus.regData = rf[bus.regAddr];

    int nCmp  = 0;
    int nFail = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rxBytes [$];
    int         rxStart [$];
    int         doneCyc [$];

    bit         rxActive = 1'b0;
    int         rxK      = 0;
    int         rxFirst  = 0;
    logic [9:0] rxBits;

    typedef struct {
        string      name;
        int         pos;
        logic [7:0] expected;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // UART decoder: sample each bit mid-period, sampling at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            rxActive = 1'b0;
        end else if (!rxActive) begin
            if (bus.tx == 1'b0) begin
                rxActive = 1'b1;
                rxK      = 0;
                rxFirst  = cyc;
            end
        end else begin
            rxK++;
        end
        if (rst_n && rxActive && (rxK % BAUD == BAUD / 2)) begin
            rxBits[rxK / BAUD] = bus.tx;
            if (rxK / BAUD == 9) begin
                chk("uart start bit", {31'd0, rxBits[0]}, 32'd0);
                chk("uart stop bit", {31'd0, rxBits[9]}, 32'd1);
                rxBytes.push_back(rxBits[8:1]);
                rxStart.push_back(rxFirst);
                rxActive = 1'b0;
            end
        end
    end

    always @(negedge clk) if (rst_n && bus.done) doneCyc.push_back(cyc);

    function automatic logic [7:0] expByte(input int pos);
        int p, r, k;
        logic [31:0] w;
        if (pos == 0) return 8'hA5;
        p = pos - 1;
        r = p / 5;
        k = p % 5;
        w = expRf[r];
        case (k)
            0:       return 8'(r);
            1:       return w[31:24];
            2:       return w[23:16];
            3:       return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    task automatic clearRx();
        rxBytes.delete();
        rxStart.delete();
        doneCyc.delete();
    endtask

    task automatic pulseStart(output int sEdge);
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 sEdge = cyc;
        bus.start = 1'b0;
    endtask

    task automatic waitDones(input int n, input int budget, input string name);
        for (int c = 0; c < budget && doneCyc.size() < n; c++) @(posedge clk);
        chk(name, {31'd0, doneCyc.size() >= n}, 32'd1);
    endtask

    task automatic checkFrame(input int base, input string tag);
        int bad;
        if (rxBytes.size() >= base + FRAME_BYTES) begin
            for (int i = 0; i < FRAME_BYTES; i++)
                chk($sformatf("%s byte %0d", tag, i), {24'd0, rxBytes[base + i]},
                    {24'd0, expByte(i)});
            bad = 0;
            for (int i = 1; i < FRAME_BYTES; i++)
                if (rxStart[base + i] - rxStart[base + i - 1] != BYTE_CLKS) bad++;
            chk({tag, " inter-byte gaps"}, bad, 0);
        end else begin
            chk({tag, " frame present"}, rxBytes.size(), base + FRAME_BYTES);
        end
    endtask

    int s;
    int seen;

    initial begin
        bus.start = 1'b0;
        for (int r = 0; r < 32; r++) begin
            rf[r]    = 32'h11223344 + r;
            expRf[r] = 32'h11223344 + r;
        end
        vecs[0]  = '{"sync",        0,   8'hA5};
        vecs[1]  = '{"r0 index",    1,   8'h00};
        vecs[2]  = '{"r0 b3",       2,   8'h11};
        vecs[3]  = '{"r0 b2",       3,   8'h22};
        vecs[4]  = '{"r0 b1",       4,   8'h33};
        vecs[5]  = '{"r0 b0",       5,   8'h44};
        vecs[6]  = '{"r1 index",    6,   8'h01};
        vecs[7]  = '{"r1 b0",       10,  8'h45};
        vecs[8]  = '{"r16 index",   81,  8'h10};
        vecs[9]  = '{"r16 b0",      85,  8'h54};
        vecs[10] = '{"r31 index",   156, 8'h1F};
        vecs[11] = '{"r31 b0",      160, 8'h63};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset tx", {31'd0, bus.tx}, 32'd1);
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset regAddr", {27'd0, bus.regAddr}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Full dump with latency checks
        clearRx();
        pulseStart(s);
        chk("busy at start edge", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1 chk("busy one edge later", {31'd0, bus.busy}, 32'd1);
        waitDones(1, FRAME_CLKS + 200, "full dump done seen");
        #1 chk("busy low with done", {31'd0, bus.busy}, 32'd0);
        repeat (20) @(posedge clk);
        chk("full dump tx fall", rxStart.size() > 0 ? rxStart[0] : -1, s + 2);
        chk("full dump done time", doneCyc.size() > 0 ? doneCyc[0] : -1, s + FRAME_CLKS + 2);
        chk("full dump done pulses", doneCyc.size(), 1);
        chk("full dump byte count", rxBytes.size(), FRAME_BYTES);
        for (int i = 0; i < 12; i++)
            if (rxBytes.size() > vecs[i].pos)
                chk({"vec ", vecs[i].name}, {24'd0, rxBytes[vecs[i].pos]}, {24'd0, vecs[i].expected});
            else
                chk({"vec ", vecs[i].name, " present"}, rxBytes.size(), vecs[i].pos + 1);
        checkFrame(0, "full");

        // Start pulses while busy are ignored
        clearRx();
        pulseStart(s);
        for (int c = 0; c < FRAME_CLKS + 200 && doneCyc.size() == 0; c++) begin
            @(posedge clk);
            #1 bus.start = ((c % 50) == 49) && bus.busy;
        end
        bus.start = 1'b0;
        repeat (200) @(posedge clk);
        chk("ignored-start byte count", rxBytes.size(), FRAME_BYTES);
        chk("ignored-start done pulses", doneCyc.size(), 1);
        checkFrame(0, "ignored-start");

        // Word stays latched while the register changes mid-send
        clearRx();
        rf[5]    = 32'hDEADBEEF;
        expRf[5] = 32'hDEADBEEF;
        pulseStart(s);
        for (int c = 0; c < FRAME_CLKS && rxBytes.size() < 27; c++) @(negedge clk);
        chk("stability reached r5 byte 1", {31'd0, rxBytes.size() >= 27}, 32'd1);
        rf[5] = 32'h0;
        waitDones(1, FRAME_CLKS + 200, "stability done seen");
        repeat (20) @(posedge clk);
        if (rxBytes.size() >= 31) begin
            chk("r5 index", {24'd0, rxBytes[26]}, 32'h05);
            chk("r5 b3", {24'd0, rxBytes[27]}, 32'hDE);
            chk("r5 b2", {24'd0, rxBytes[28]}, 32'hAD);
            chk("r5 b1", {24'd0, rxBytes[29]}, 32'hBE);
            chk("r5 b0", {24'd0, rxBytes[30]}, 32'hEF);
        end else begin
            chk("stability bytes present", rxBytes.size(), 31);
        end
        checkFrame(0, "stability");
        rf[5]    = 32'h11223344 + 5;
        expRf[5] = 32'h11223344 + 5;

        // Reset in the middle of byte 40, then a clean frame
        clearRx();
        pulseStart(s);
        for (int c = 0; c < FRAME_CLKS && !(rxBytes.size() >= 40 && bus.tx == 1'b0); c++)
            @(negedge clk);
        chk("reached byte 40 low bit", {31'd0, rxBytes.size() >= 40 && bus.tx == 1'b0}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-reset tx", {31'd0, bus.tx}, 32'd1);
        chk("mid-reset busy", {31'd0, bus.busy}, 32'd0);
        chk("mid-reset done", {31'd0, bus.done}, 32'd0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        chk("idle after reset tx", {31'd0, bus.tx}, 32'd1);
        clearRx();
        pulseStart(s);
        waitDones(1, FRAME_CLKS + 200, "post-reset done seen");
        repeat (20) @(posedge clk);
        chk("post-reset byte count", rxBytes.size(), FRAME_BYTES);
        checkFrame(0, "post-reset");

        // Start held high: back-to-back frames
        clearRx();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 s = cyc;
        waitDones(1, FRAME_CLKS + 200, "b2b first done seen");
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(posedge clk);
            #1 if (bus.busy) seen = 1;
        end
        bus.start = 1'b0;
        chk("b2b second frame busy", seen, 1);
        waitDones(2, FRAME_CLKS + 200, "b2b second done seen");
        repeat (100) @(posedge clk);
        chk("b2b done pulses", doneCyc.size(), 2);
        chk("b2b byte count", rxBytes.size(), 2 * FRAME_BYTES);
        chk("b2b first done time", doneCyc.size() > 0 ? doneCyc[0] : -1, s + FRAME_CLKS + 2);
        chk("b2b second tx fall",
            (rxStart.size() > FRAME_BYTES) ? rxStart[FRAME_BYTES] : -1,
            (doneCyc.size() > 0) ? doneCyc[0] + 3 : -2);
        checkFrame(0, "b2b first");
        checkFrame(FRAME_BYTES, "b2b second");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
